// File: rtl/lfsr_pkg.sv
// Shared definitions for the pixel LFSR sequencer.
//   MAX_PIXEL_BITS : width of the pixel LFSR
//   pixel_t        : one LFSR output word
//   seq_state_e    : sequencer FSM states (explicit encodings)
//   CFG_*_SEL      : values driven on the LFSR config select line
package lfsr_pkg;

  localparam int MAX_PIXEL_BITS = 24;

  typedef logic [MAX_PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CFG_SEED   = 4'd1,
    ST_WAIT_SEED  = 4'd2,
    ST_CFG_UNSTK  = 4'd3,
    ST_WAIT_UNSTK = 4'd4,
    ST_CFG_STOP   = 4'd5,
    ST_WAIT_STOP  = 4'd6,
    ST_LOAD       = 4'd7,
    ST_RUN        = 4'd8,
    ST_DRAIN      = 4'd9,
    ST_DONE       = 4'd10
  } seq_state_e;

  localparam logic CFG_SEED_SEL = 1'b0;
  localparam logic CFG_STOP_SEL = 1'b1;

endpackage

// File: rtl/lfsr_seq_fifo.sv
// Synchronous FIFO holding {last, pixel} entries toward the pixel consumer.
//   clk_i, nreset_i : clock, synchronous active-low reset
//   push, push_data : write request and entry
//   pop             : read request (ignored when empty)
//   pop_data        : head entry, stable until popped
//   full, empty     : occupancy status
// A push while full is accepted only if a pop frees the slot in the same
// cycle; otherwise the entry is dropped and the caller flags overflow.
module lfsr_seq_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the 24-bit pixel LFSR.
//   Host side : start_i, seed_i, stop_i in; busy_o, done_o, timeout_o,
//               cfg_err_o, ovf_o, pix_count_o out.
//   LFSR side : cfg_sel_o/cfg_rdy_o/cfg_data_o config write, cfg_done_i and
//               cfg_rdbk_i readback; lfsr_en_o run enable; lfsr_out_i,
//               lfsr_rdy_i, lfsr_done_i generator status.
//   Pixel side: pix_o, pix_last_o, pix_valid_o from a FIFO; pix_ready_i.
// Handshakes: a pixel transfers on a cycle where pix_valid_o && pix_ready_i;
// pix_o/pix_last_o hold until then. A config write is a one-cycle cfg_rdy_o
// pulse, after which the sequencer waits (unbounded) for cfg_done_i.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int PIX_W      = MAX_PIXEL_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_PIXELS = 16777215,
  parameter int CNT_W      = 24
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             start_i,
  input  logic [PIX_W-1:0] seed_i,
  input  logic [PIX_W-1:0] stop_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             cfg_err_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] pix_count_o,
  output logic             cfg_sel_o,
  output logic             cfg_rdy_o,
  output logic [PIX_W-1:0] cfg_data_o,
  input  logic             cfg_done_i,
  input  logic [PIX_W-1:0] cfg_rdbk_i,
  output logic             lfsr_en_o,
  input  logic [PIX_W-1:0] lfsr_out_i,
  input  logic             lfsr_rdy_i,
  input  logic             lfsr_done_i,
  output logic [PIX_W-1:0] pix_o,
  output logic             pix_last_o,
  output logic             pix_valid_o,
  input  logic             pix_ready_i
);

  seq_state_e       state;
  logic [PIX_W-1:0] seed_r;
  logic [PIX_W-1:0] stop_r;
  logic [PIX_W-1:0] cfg_val;   // value written by the last config write
  logic [PIX_W-1:0] cfg_wdata;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_r;
  logic             cfg_err_r;
  logic             ovf_r;
  logic             push;
  logic             pop;
  logic             drop;
  logic             hit_max;
  logic             fifo_full;
  logic             fifo_empty;

  always_comb begin
    cfg_wdata = cfg_val;
    case (state)
      ST_CFG_SEED:  cfg_wdata = seed_r;
      // Writing the complement of the current output forces stop != out,
      // releasing a stale stop-reached hold so the seed can reload.
      ST_CFG_UNSTK: cfg_wdata = ~lfsr_out_i;
      ST_CFG_STOP:  cfg_wdata = stop_r;
      default:      cfg_wdata = cfg_val;
    endcase
  end

  always_comb begin
    busy_o     = (state != ST_IDLE);
    done_o     = (state == ST_DONE);
    lfsr_en_o  = (state == ST_RUN);
    cfg_rdy_o  = (state == ST_CFG_SEED) || (state == ST_CFG_UNSTK) ||
                 (state == ST_CFG_STOP);
    cfg_sel_o  = CFG_SEED_SEL;
    cfg_data_o = '0;
    case (state)
      ST_CFG_SEED, ST_WAIT_SEED: cfg_data_o = cfg_wdata;
      ST_CFG_UNSTK, ST_WAIT_UNSTK, ST_CFG_STOP, ST_WAIT_STOP: begin
        cfg_sel_o  = CFG_STOP_SEL;
        cfg_data_o = cfg_wdata;
      end
      default: cfg_data_o = '0;
    endcase
  end

  assign push     = (state == ST_RUN) && lfsr_rdy_i;
  assign pop      = pix_valid_o && pix_ready_i;
  assign drop     = push && fifo_full && !pop;
  assign cnt_next = count + 1'b1;
  // Abort on the push that reaches the limit so no extra pixel slips in.
  assign hit_max  = push && (cnt_next == CNT_W'(MAX_PIXELS));

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state     <= ST_IDLE;
      seed_r    <= '0;
      stop_r    <= '0;
      cfg_val   <= '0;
      count     <= '0;
      timeout_r <= 1'b0;
      cfg_err_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          seed_r    <= seed_i;
          stop_r    <= stop_i;
          count     <= '0;
          timeout_r <= 1'b0;
          cfg_err_r <= 1'b0;
          ovf_r     <= 1'b0;
          state     <= ST_CFG_SEED;
        end
        ST_CFG_SEED:  begin cfg_val <= cfg_wdata; state <= ST_WAIT_SEED;  end
        ST_CFG_UNSTK: begin cfg_val <= cfg_wdata; state <= ST_WAIT_UNSTK; end
        ST_CFG_STOP:  begin cfg_val <= cfg_wdata; state <= ST_WAIT_STOP;  end
        ST_WAIT_SEED, ST_WAIT_UNSTK, ST_WAIT_STOP: if (cfg_done_i) begin
          if (cfg_rdbk_i != cfg_val) cfg_err_r <= 1'b1;
          case (state)
            ST_WAIT_SEED:  state <= ST_CFG_UNSTK;
            ST_WAIT_UNSTK: state <= ST_CFG_STOP;
            default:       state <= ST_LOAD;
          endcase
        end
        ST_LOAD: state <= ST_RUN;
        ST_RUN: begin
          if (push) count <= cnt_next;
          if (drop) ovf_r <= 1'b1;
          if (hit_max) begin
            timeout_r <= 1'b1;
            state     <= ST_DRAIN;
          end else if (lfsr_done_i && !lfsr_rdy_i) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (fifo_empty) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign timeout_o   = timeout_r;
  assign cfg_err_o   = cfg_err_r;
  assign ovf_o       = ovf_r;
  assign pix_count_o = count;
  assign pix_valid_o = !fifo_empty;

  lfsr_seq_fifo #(
    .W     (PIX_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .push      (push),
    .push_data ({(lfsr_out_i == stop_r), lfsr_out_i}),
    .pop       (pop),
    .pop_data  ({pix_last_o, pix_o}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural pixel LFSR model.
// LFSR model: shift left, XNOR feedback of bits 23,22,21,16 (1 -> 3 -> 7 -> F),
// config_done one cycle after config_rdy, holds its output while out == stop,
// otherwise reloads the seed whenever enable is low.
module tb_lfsr_seq_ctrl;
  import lfsr_pkg::*;

  localparam int PIX_W = 24;
  localparam int CNT_W = 24;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             nreset, start, pix_ready;
  logic [PIX_W-1:0] seed, stop;
  logic             busy, done, timeout, cfg_err, ovf;
  logic [CNT_W-1:0] pix_count;
  logic             cfg_sel, cfg_rdy, cfg_done;
  logic [PIX_W-1:0] cfg_data, cfg_rdbk;
  logic             lfsr_en, lfsr_rdy, lfsr_done;
  logic [PIX_W-1:0] lfsr_out, pix;
  logic             pix_last, pix_valid;

  lfsr_seq_ctrl #(.PIX_W(PIX_W), .FIFO_DEPTH(4), .MAX_PIXELS(8), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .nreset_i(nreset), .start_i(start), .seed_i(seed), .stop_i(stop),
    .busy_o(busy), .done_o(done), .timeout_o(timeout), .cfg_err_o(cfg_err),
    .ovf_o(ovf), .pix_count_o(pix_count), .cfg_sel_o(cfg_sel), .cfg_rdy_o(cfg_rdy),
    .cfg_data_o(cfg_data), .cfg_done_i(cfg_done), .cfg_rdbk_i(cfg_rdbk),
    .lfsr_en_o(lfsr_en), .lfsr_out_i(lfsr_out), .lfsr_rdy_i(lfsr_rdy),
    .lfsr_done_i(lfsr_done), .pix_o(pix), .pix_last_o(pix_last),
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready)
  );

  // ---------------- LFSR model ----------------
  logic [PIX_W-1:0] m_seed = '0, m_stop = '0, m_out = '0;
  logic             m_rdy = 1'b0, m_cfg_done = 1'b0, m_corrupt = 1'b0;

  function automatic logic [PIX_W-1:0] lfsr_next(input logic [PIX_W-1:0] v);
    return {v[22:0], ~(v[23] ^ v[22] ^ v[21] ^ v[16])};
  endfunction

  assign lfsr_out  = m_out;
  assign lfsr_rdy  = m_rdy;
  assign lfsr_done = (m_out == m_stop);
  assign cfg_done  = m_cfg_done;
  assign cfg_rdbk  = cfg_sel ? (m_stop ^ {23'd0, m_corrupt}) : m_seed;

  always @(posedge clk) begin
    if (cfg_rdy) begin
      if (cfg_sel) m_stop <= cfg_data;
      else         m_seed <= cfg_data;
      m_cfg_done <= 1'b1;
    end else begin
      m_cfg_done <= 1'b0;
    end
    if (m_out == m_stop) begin
      m_rdy <= 1'b0;
    end else if (!lfsr_en) begin
      m_out <= m_seed;
      m_rdy <= 1'b0;
    end else begin
      m_out <= lfsr_next(m_out);
      m_rdy <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [PIX_W:0]   exp_q[$];
  logic [PIX_W:0]   got_q[$];
  logic [PIX_W-1:0] stopw_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int en_drain_bad = 0;
  bit valid_seen = 0;

  always @(negedge clk) begin
    if (pix_valid && pix_ready) got_q.push_back({pix_last, pix});
    if (done) done_cnt++;
    if (pix_valid) valid_seen = 1'b1;
    if (dut.state == ST_DRAIN && lfsr_en) en_drain_bad++;
    if (cfg_rdy && cfg_sel) stopw_q.push_back(cfg_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_pixels(input string tag);
    chk({tag, " pixel_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s pixel[%0d]", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [PIX_W-1:0] s, input logic [PIX_W-1:0] p);
    got_q.delete();
    stopw_q.delete();
    @(posedge clk); #1;
    seed = s; stop = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk({tag, " done_reached"}, 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input seq_state_e st, input string tag);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dut.state == st) begin seen = 1; break; end
    end
    chk({tag, " state_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " timeout"}, 32'(timeout), 0);
    chk({tag, " cfg_err"}, 32'(cfg_err), 0);
    chk({tag, " ovf"}, 32'(ovf), 0);
    chk({tag, " count"}, 32'(pix_count), 0);
    chk({tag, " cfg_sel"}, 32'(cfg_sel), 0);
    chk({tag, " cfg_rdy"}, 32'(cfg_rdy), 0);
    chk({tag, " cfg_data"}, 32'(cfg_data), 0);
    chk({tag, " lfsr_en"}, 32'(lfsr_en), 0);
    chk({tag, " pix"}, 32'(pix), 0);
    chk({tag, " pix_last"}, 32'(pix_last), 0);
    chk({tag, " pix_valid"}, 32'(pix_valid), 0);
  endtask

  // ---------------- directed sequence ----------------
  int d0;
  initial begin
    nreset = 1'b0; start = 1'b0; seed = '0; stop = '0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    nreset = 1'b1;

    // Basic run: 1 -> 3, 7, F with stop F.
    d0 = done_cnt;
    exp_q = '{{1'b0, 24'h000003}, {1'b0, 24'h000007}, {1'b1, 24'h00000F}};
    start_run(24'h000001, 24'h00000F);
    wait_done("basic");
    chk("basic count", 32'(pix_count), 3);
    chk("basic done_pulses", done_cnt - d0, 1);
    chk("basic flags", {29'd0, timeout, cfg_err, ovf}, 0);
    chk("basic busy_idle", 32'(busy), 0);
    chk("basic stop_writes", stopw_q.size(), 2);
    if (stopw_q.size() == 2) chk("basic stop_value", 32'(stopw_q[1]), 32'h00000F);
    check_pixels("basic");

    // Identical rerun: unstick writes ~F, same pixels again.
    d0 = done_cnt;
    exp_q = '{{1'b0, 24'h000003}, {1'b0, 24'h000007}, {1'b1, 24'h00000F}};
    start_run(24'h000001, 24'h00000F);
    wait_done("rerun");
    chk("rerun count", 32'(pix_count), 3);
    chk("rerun done_pulses", done_cnt - d0, 1);
    if (stopw_q.size() > 0) chk("rerun unstick_value", 32'(stopw_q[0]), 32'hFFFFF0);
    else chk("rerun unstick_writes", stopw_q.size(), 2);
    check_pixels("rerun");

    // seed == stop: zero-length run.
    d0 = done_cnt;
    valid_seen = 1'b0;
    start_run(24'h000005, 24'h000005);
    wait_done("zero");
    chk("zero count", 32'(pix_count), 0);
    chk("zero valid_seen", 32'(valid_seen), 0);
    chk("zero done_pulses", done_cnt - d0, 1);
    check_pixels("zero");

    // Timeout at MAX_PIXELS=8.
    d0 = done_cnt;
    en_drain_bad = 0;
    exp_q = '{{1'b0, 24'h000003}, {1'b0, 24'h000007}, {1'b0, 24'h00000F},
              {1'b0, 24'h00001F}, {1'b0, 24'h00003F}, {1'b0, 24'h00007F},
              {1'b0, 24'h0000FF}, {1'b0, 24'h0001FF}};
    start_run(24'h000001, 24'hFFFFFF);
    wait_done("tmo");
    chk("tmo count", 32'(pix_count), 8);
    chk("tmo timeout", 32'(timeout), 1);
    chk("tmo en_in_drain", en_drain_bad, 0);
    chk("tmo done_pulses", done_cnt - d0, 1);
    check_pixels("tmo");

    // Overflow: consumer stalled during a 6-pixel run.
    pix_ready = 1'b0;
    start_run(24'h000001, 24'h00007F);
    wait_state(ST_DRAIN, "ovf");
    chk("ovf ovf", 32'(ovf), 1);
    chk("ovf count", 32'(pix_count), 6);
    chk("ovf valid", 32'(pix_valid), 1);
    chk("ovf head_hold", {7'd0, pix_last, pix}, 32'h000003);
    chk("ovf no_done", 32'(done), 0);
    @(posedge clk); #1;
    pix_ready = 1'b1;
    exp_q = '{{1'b0, 24'h000003}, {1'b0, 24'h000007}, {1'b0, 24'h00000F},
              {1'b0, 24'h00001F}};
    wait_done("ovf");
    check_pixels("ovf");

    // Corrupted stop readback: error flagged, run completes.
    m_corrupt = 1'b1;
    d0 = done_cnt;
    exp_q = '{{1'b0, 24'h000003}, {1'b0, 24'h000007}, {1'b1, 24'h00000F}};
    start_run(24'h000001, 24'h00000F);
    wait_done("cerr");
    m_corrupt = 1'b0;
    chk("cerr cfg_err", 32'(cfg_err), 1);
    chk("cerr done_pulses", done_cnt - d0, 1);
    check_pixels("cerr");

    // Reset in the middle of RUN.
    d0 = done_cnt;
    start_run(24'h000001, 24'hFFFFFF);
    wait_state(ST_RUN, "mid_rst");
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_rst");
    chk("mid_rst state_idle", 32'(dut.state == ST_IDLE), 1);
    @(posedge clk); #1;
    nreset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst no_done", done_cnt - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
